// File: rtl/julia_pkg.sv
// Shared fixed-point types, thresholds and FSM encoding for the Julia escape-time engine.
package julia_pkg;
  localparam int FRACTIONAL = 11;
  localparam int INTEGRAL   = 11;
  localparam int WIDTH      = FRACTIONAL + INTEGRAL;

  typedef logic signed [WIDTH-1:0] fixed_t;

  localparam fixed_t FIX_TWO  = fixed_t'(4096);
  localparam fixed_t FIX_FOUR = fixed_t'(8192);

  typedef enum logic [1:0] {
    IDLE,
    ITERATE,
    DONE
  } state_t;
endpackage

// File: rtl/escape_check.sv
// Combinational escape test: component magnitude above 2.0, or squared magnitude above 4.0.
module escape_check
  import julia_pkg::*;
(
  input  fixed_t zr,
  input  fixed_t zi,
  input  fixed_t sr,
  input  fixed_t si,
  output logic   esc
);
  logic signed [WIDTH:0] sum;
  logic                  comp_out;

  // Signed compares avoid taking |x| of the most negative code.
  assign comp_out = (zr > FIX_TWO) || (zr < -FIX_TWO) || (zi > FIX_TWO) || (zi < -FIX_TWO);
  assign sum      = (WIDTH+1)'(sr) + (WIDTH+1)'(si);
  assign esc      = comp_out || (sum > $signed({1'b0, FIX_FOUR}));
endmodule

// File: rtl/fixed_multiplication.sv
// Signed fixed-point multiply; the double-width product is arithmetically shifted and truncated to WIDTH.
module fixed_multiplication #(
  parameter int WIDTH      = 22,
  parameter int FRACTIONAL = 11
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] product
);
  logic signed [2*WIDTH-1:0] full;

  assign full    = a * b;
  assign product = WIDTH'(full >>> FRACTIONAL);
endmodule

// File: rtl/julia_iterator.sv
// Per-pixel escape-time engine: iterates z <- z^2 + c until |z| leaves radius 2 or the cap is hit.
// state   | meaning
// IDLE    | waiting for start; operands latched on start
// ITERATE | one escape check / update per clock
// DONE    | one-cycle done pulse, results valid
module julia_iterator
  import julia_pkg::*;
#(
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  fixed_t            z0_re,
  input  fixed_t            z0_im,
  input  fixed_t            c_re,
  input  fixed_t            c_im,
  input  logic [ITER_W-1:0] max_iter,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_count,
  output logic              escaped
);
  state_t            state, state_nxt;
  fixed_t            zr, zi, cr, ci;
  fixed_t            sr, si, p;
  logic [ITER_W-1:0] cap, count;
  logic              esc;
  logic              at_cap;

  fixed_multiplication #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL)) u_mul_sr (.a(zr), .b(zr), .product(sr));
  fixed_multiplication #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL)) u_mul_si (.a(zi), .b(zi), .product(si));
  fixed_multiplication #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL)) u_mul_p  (.a(zr), .b(zi), .product(p));

  escape_check u_escape_check (.zr(zr), .zi(zi), .sr(sr), .si(si), .esc(esc));

  assign at_cap = (count == cap);
  assign busy   = (state == ITERATE);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ITERATE;
      ITERATE: if (esc || at_cap) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      zr         <= '0;
      zi         <= '0;
      cr         <= '0;
      ci         <= '0;
      cap        <= '0;
      count      <= '0;
      iter_count <= '0;
      escaped    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            zr    <= z0_re;
            zi    <= z0_im;
            cr    <= c_re;
            ci    <= c_im;
            cap   <= max_iter;
            count <= '0;
          end
        end
        ITERATE: begin
          if (esc) begin
            escaped    <= 1'b1;
            iter_count <= count;
          end else if (at_cap) begin
            escaped    <= 1'b0;
            iter_count <= count;
          end else begin
            // Two's-complement wrap at WIDTH is intended; the guard keeps it from mattering.
            zr    <= sr - si + cr;
            zi    <= (p <<< 1) + ci;
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_julia_iterator.sv
// Directed bench for julia_iterator: table of jobs with hand-computed results plus start-ignore and mid-run reset sequences.
module tb_julia_iterator;
  logic               clk;
  logic               n_rst;
  logic               start;
  logic signed [21:0] z0_re, z0_im, c_re, c_im;
  logic [7:0]         max_iter;
  logic               busy, done, escaped;
  logic [7:0]         iter_count;

  int n_pass;
  int n_total;

  typedef struct {
    logic signed [21:0] zr;
    logic signed [21:0] zi;
    logic signed [21:0] cr;
    logic signed [21:0] ci;
    logic [7:0]         mi;
    logic               exp_esc;
    int                 exp_cnt;
    int                 exp_lat;
  } vec_t;

  vec_t vecs [9];

  julia_iterator #(.ITER_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .z0_re(z0_re), .z0_im(z0_im), .c_re(c_re), .c_im(c_im),
    .max_iter(max_iter), .busy(busy), .done(done),
    .iter_count(iter_count), .escaped(escaped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic launch(input vec_t v);
    @(negedge clk);
    z0_re = v.zr; z0_im = v.zi; c_re = v.cr; c_im = v.ci; max_iter = v.mi;
    start = 1'b1;
    @(posedge clk);
  endtask

  // Counts negedges after the start-sample edge until done is seen (bounded).
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0; busy_n = 0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) busy_n++;
      if (done || lat >= 300) break;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat, input int busy_n);
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " escaped"}, int'(escaped), int'(v.exp_esc));
    check({tag, " iter_count"}, int'(iter_count), v.exp_cnt);
    check({tag, " busy cycles"}, busy_n, v.exp_lat - 1);
    @(negedge clk);
    check({tag, " done width"}, int'(done), 0);
    check({tag, " idle busy"}, int'(busy), 0);
  endtask

  initial begin
    int lat, busy_n;
    n_pass = 0; n_total = 0;
    n_rst = 1'b0; start = 1'b0;
    z0_re = '0; z0_im = '0; c_re = '0; c_im = '0; max_iter = '0;

    //          zr     zi    cr     ci    mi  esc cnt lat
    vecs[0] = '{22'sd0,     22'sd0,    22'sd0,     22'sd0,    8'd10, 1'b0, 10, 12};
    vecs[1] = '{22'sd6144,  22'sd0,    22'sd0,     22'sd0,    8'd50, 1'b1, 0,  2};
    vecs[2] = '{22'sd0,     22'sd0,    22'sd2048,  22'sd0,    8'd50, 1'b1, 3,  5};
    vecs[3] = '{22'sd0,     22'sd0,    -22'sd4096, 22'sd0,    8'd20, 1'b0, 20, 22};
    vecs[4] = '{22'sd0,     22'sd0,    22'sd0,     22'sd0,    8'd0,  1'b0, 0,  2};
    vecs[5] = '{22'sd0,     22'sd4096, 22'sd0,     22'sd0,    8'd5,  1'b1, 1,  3};
    vecs[6] = '{-22'sd4097, 22'sd0,    22'sd0,     22'sd0,    8'd9,  1'b1, 0,  2};
    vecs[7] = '{22'sd3072,  22'sd3072, 22'sd0,     22'sd0,    8'd9,  1'b1, 0,  2};
    vecs[8] = '{22'sd0,     22'sd0,    22'sd0,     22'sd2048, 8'd8,  1'b0, 8,  10};

    repeat (2) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset iter_count", int'(iter_count), 0);
    check("reset escaped", int'(escaped), 0);
    n_rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      launch(vecs[i]);
      wait_done(lat, busy_n);
      check_result($sformatf("vec%0d", i), vecs[i], lat, busy_n);
    end

    // Second start while running must be ignored; operand inputs change too.
    launch(vecs[3]);
    lat = 0; busy_n = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (lat == 4) begin
        start = 1'b1; z0_re = 22'sd6144; c_re = 22'sd0; max_iter = 8'd1;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_n++;
      if (done || lat >= 300) break;
    end
    check_result("restart", vecs[3], lat, busy_n);

    // Reset at count 5 of a running job.
    launch(vecs[3]);
    repeat (6) @(negedge clk);
    start = 1'b0;
    check("pre-reset busy", int'(busy), 1);
    n_rst = 1'b0;
    #1;
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst iter_count", int'(iter_count), 0);
    check("rst escaped", int'(escaped), 0);
    begin
      int seen = 0;
      repeat (3) begin
        @(negedge clk);
        if (done) seen++;
      end
      check("rst no done", seen, 0);
    end
    n_rst = 1'b1;
    launch(vecs[2]);
    wait_done(lat, busy_n);
    check_result("post-reset", vecs[2], lat, busy_n);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
